// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator RAM port-A arbiter: owner encoding and
// statistics counter width, plus the saturating-increment helper.
package cfg_types_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_ACC  = 2'd2
  } arb_owner_t;

  localparam int ARB_STATS_WIDTH = 16;

  function automatic logic [ARB_STATS_WIDTH-1:0] sat_inc(input logic [ARB_STATS_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/accel_arb_stats.sv
// Saturating stall counters for the CPU and accelerator requesters.
// Synchronous clear takes priority over the increment.
module accel_arb_stats
  import cfg_types_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       cpu_stall_i,
  input  logic                       acc_stall_i,
  output logic [ARB_STATS_WIDTH-1:0] cpu_cnt_o,
  output logic [ARB_STATS_WIDTH-1:0] acc_cnt_o
);

  logic [ARB_STATS_WIDTH-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [ARB_STATS_WIDTH-1:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    acc_cnt_d = acc_cnt_q;
    if (clr_i) begin
      cpu_cnt_d = '0;
      acc_cnt_d = '0;
    end else begin
      if (cpu_stall_i) cpu_cnt_d = sat_inc(cpu_cnt_q);
      if (acc_stall_i) acc_cnt_d = sat_inc(acc_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign cpu_cnt_o = cpu_cnt_q;
  assign acc_cnt_o = acc_cnt_q;

endmodule

// File: rtl/accel_mem_arbiter.sv
// Port-A arbiter sharing the accelerator RAM between CPU bus and Keccak FSM.
// Define ACCEL_ARB_STATS_EN to add per-requester stall counters.
module accel_mem_arbiter
  import cfg_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cpu_be_i,
  output logic                      cpu_gnt_o,
  output logic                      cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     cpu_rdata_o,
  input  logic                      acc_req_i,
  input  logic                      acc_we_i,
  input  logic [ADDR_WIDTH-1:0]     acc_addr_i,
  input  logic [DATA_WIDTH-1:0]     acc_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   acc_be_i,
  output logic                      acc_gnt_o,
  output logic                      acc_rvalid_o,
  output logic [DATA_WIDTH-1:0]     acc_rdata_o,
  input  logic                      acc_lock_i,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
`ifdef ACCEL_ARB_STATS_EN
  input  logic                      stats_clr_i,
  output logic [ARB_STATS_WIDTH-1:0] cpu_stall_cnt_o,
  output logic [ARB_STATS_WIDTH-1:0] acc_stall_cnt_o,
`endif
  output arb_owner_t                owner_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
  arb_owner_t        last_owner_q, last_owner_d;
  logic              tag_vld_q, tag_vld_d;
  arb_owner_t        tag_own_q, tag_own_d;
  logic              tag_we_q, tag_we_d;
  logic              cpu_wins_tie;

  // Under lock the CPU only gets through once its wait has hit the bound;
  // otherwise ties alternate against the last granted requester.
  always_comb begin
    if (acc_lock_i) cpu_wins_tie = (cpu_wait_q == WAIT_W'(MAX_WAIT));
    else            cpu_wins_tie = (last_owner_q == OWN_ACC);
  end

  // Grants are forced low while reset is held so every output reads zero.
  assign cpu_gnt_o = rst_n && cpu_req_i && (!acc_req_i || cpu_wins_tie);
  assign acc_gnt_o = rst_n && acc_req_i && !cpu_gnt_o;

  always_comb begin
    owner_o = OWN_NONE;
    if (cpu_gnt_o)      owner_o = OWN_CPU;
    else if (acc_gnt_o) owner_o = OWN_ACC;
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (cpu_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_be_o    = cpu_be_i;
    end else if (acc_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = acc_we_i;
      mem_addr_o  = acc_addr_i;
      mem_wdata_o = acc_wdata_i;
      mem_be_o    = acc_be_i;
    end
  end

  always_comb begin
    cpu_wait_d = cpu_wait_q;
    if (!cpu_req_i || cpu_gnt_o)            cpu_wait_d = '0;
    else if (cpu_wait_q != WAIT_W'(MAX_WAIT)) cpu_wait_d = cpu_wait_q + 1'b1;
    last_owner_d = (owner_o != OWN_NONE) ? owner_o : last_owner_q;
    tag_vld_d    = (owner_o != OWN_NONE);
    tag_own_d    = owner_o;
    tag_we_d     = mem_we_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wait_q   <= '0;
      last_owner_q <= OWN_ACC;
      tag_vld_q    <= 1'b0;
      tag_own_q    <= OWN_NONE;
      tag_we_q     <= 1'b0;
    end else begin
      cpu_wait_q   <= cpu_wait_d;
      last_owner_q <= last_owner_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
      tag_we_q     <= tag_we_d;
    end
  end

  assign cpu_rvalid_o = tag_vld_q && (tag_own_q == OWN_CPU);
  assign acc_rvalid_o = tag_vld_q && (tag_own_q == OWN_ACC);
  assign cpu_rdata_o  = (cpu_rvalid_o && !tag_we_q) ? mem_rdata_i : '0;
  assign acc_rdata_o  = (acc_rvalid_o && !tag_we_q) ? mem_rdata_i : '0;

`ifdef ACCEL_ARB_STATS_EN
  accel_arb_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (stats_clr_i),
    .cpu_stall_i (cpu_req_i && !cpu_gnt_o),
    .acc_stall_i (acc_req_i && !acc_gnt_o),
    .cpu_cnt_o   (cpu_stall_cnt_o),
    .acc_cnt_o   (acc_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed bench for accel_mem_arbiter with a small behavioural RAM on port A.
module tb_accel_mem_arbiter;
  import cfg_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        acc_req, acc_we, acc_gnt, acc_rvalid, acc_lock;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;
  logic [3:0]  acc_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  arb_owner_t  owner;
`ifdef ACCEL_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] cpu_stall_cnt, acc_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_be_i(cpu_be), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .acc_req_i(acc_req), .acc_we_i(acc_we), .acc_addr_i(acc_addr), .acc_wdata_i(acc_wdata),
    .acc_be_i(acc_be), .acc_gnt_o(acc_gnt), .acc_rvalid_o(acc_rvalid), .acc_rdata_o(acc_rdata),
    .acc_lock_i(acc_lock),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
`ifdef ACCEL_ARB_STATS_EN
    .stats_clr_i(stats_clr), .cpu_stall_cnt_o(cpu_stall_cnt), .acc_stall_cnt_o(acc_stall_cnt),
`endif
    .owner_o(owner)
  );

  // RAM port A: registered read, byte-masked write; word 4 preloaded in reset.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[4] <= 32'hDEADBEEF;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    acc_req = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0; acc_be = '0;
    acc_lock = 0;
`ifdef ACCEL_ARB_STATS_EN
    stats_clr = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) tick();
    n_cmp++; if (cpu_gnt !== 1'b0 || acc_gnt !== 1'b0) begin n_err++;
      $display("FAIL reset_gnt got %b/%b want 0/0", cpu_gnt, acc_gnt); end
    n_cmp++; if (cpu_rvalid !== 1'b0 || acc_rvalid !== 1'b0) begin n_err++;
      $display("FAIL reset_rvalid got %b/%b want 0/0", cpu_rvalid, acc_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'h0 || acc_rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata got %h/%h want 0/0", cpu_rdata, acc_rdata); end
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin n_err++;
      $display("FAIL reset_mem got en=%b we=%b a=%h d=%h be=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata, mem_be); end
    n_cmp++; if (owner !== OWN_NONE) begin n_err++;
      $display("FAIL reset_owner got %0d want %0d", owner, OWN_NONE); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_round_robin();
    arb_owner_t exp;
    idle();
    cpu_req = 1; cpu_addr = 32'h20; acc_req = 1; acc_addr = 32'h24;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i % 2 == 0) ? OWN_CPU : OWN_ACC;
      n_cmp++; if (owner !== exp) begin n_err++;
        $display("FAIL rr_owner[%0d] got %0d want %0d", i, owner, exp); end
      n_cmp++; if (cpu_gnt !== (exp == OWN_CPU) || acc_gnt !== (exp == OWN_ACC)) begin n_err++;
        $display("FAIL rr_gnt[%0d] got cpu=%b acc=%b", i, cpu_gnt, acc_gnt); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_single_read();
    idle();
    cpu_req = 1; cpu_addr = 32'h04; cpu_be = 4'hF;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1 || acc_gnt !== 1'b0) begin n_err++;
      $display("FAIL rd_gnt got cpu=%b acc=%b want 1/0", cpu_gnt, acc_gnt); end
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h04) begin n_err++;
      $display("FAIL rd_mem got en=%b we=%b a=%h want 1/0/04", mem_en, mem_we, mem_addr); end
    tick();
    idle();
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL rd_resp got v=%b d=%h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
    n_cmp++; if (acc_rvalid !== 1'b0 || acc_rdata !== 32'h0) begin n_err++;
      $display("FAIL rd_other got v=%b d=%h want 0/0", acc_rvalid, acc_rdata); end
    tick();
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++;
      $display("FAIL rd_single_pulse got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_lock();
    arb_owner_t exp;
    idle();
    cpu_req = 1; cpu_addr = 32'h30; acc_req = 1; acc_addr = 32'h34; acc_lock = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp = (i == 16) ? OWN_CPU : OWN_ACC;
      n_cmp++; if (owner !== exp) begin n_err++;
        $display("FAIL lock_owner[%0d] got %0d want %0d", i, owner, exp); end
      tick();
    end
    // Lock drops with both pending: last grant was ACC, so CPU wins now.
    acc_lock = 0;
    #1;
    n_cmp++; if (owner !== OWN_CPU) begin n_err++;
      $display("FAIL unlock_owner got %0d want %0d", owner, OWN_CPU); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    acc_req = 1; acc_we = 1; acc_addr = 32'h10; acc_wdata = 32'h12345678; acc_be = 4'hF;
    #1;
    n_cmp++; if (acc_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h12345678) begin n_err++;
      $display("FAIL wr_mem got g=%b we=%b a=%h d=%h", acc_gnt, mem_we, mem_addr, mem_wdata); end
    tick();
    idle();
    cpu_req = 1; cpu_addr = 32'h10; cpu_be = 4'hF;
    #1;
    n_cmp++; if (acc_rvalid !== 1'b1 || acc_rdata !== 32'h0) begin n_err++;
      $display("FAIL wr_resp got v=%b d=%h want 1/0", acc_rvalid, acc_rdata); end
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b1) begin n_err++;
      $display("FAIL b2b_cpu got rv=%b g=%b want 0/1", cpu_rvalid, cpu_gnt); end
    tick();
    idle();
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin n_err++;
      $display("FAIL b2b_read got v=%b d=%h want 1/12345678", cpu_rvalid, cpu_rdata); end
    n_cmp++; if (acc_rvalid !== 1'b0) begin n_err++;
      $display("FAIL b2b_acc got %b want 0", acc_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    cpu_req = 1; cpu_addr = 32'h04; cpu_be = 4'hF;
    tick();
    rst_n = 0;
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin n_err++;
      $display("FAIL midrst_rvalid got v=%b d=%h want 0/0", cpu_rvalid, cpu_rdata); end
    n_cmp++; if (cpu_gnt !== 1'b0 || mem_en !== 1'b0 || owner !== OWN_NONE) begin n_err++;
      $display("FAIL midrst_out got g=%b en=%b own=%0d want 0/0/0", cpu_gnt, mem_en, owner); end
    idle();
    repeat (2) tick();
    rst_n = 1;
    tick();
    cpu_req = 1; acc_req = 1;
    #1;
    n_cmp++; if (owner !== OWN_CPU) begin n_err++;
      $display("FAIL midrst_tie got %0d want %0d", owner, OWN_CPU); end
    tick();
    idle();
    tick();
  endtask

`ifdef ACCEL_ARB_STATS_EN
  task automatic test_stats();
    idle();
    stats_clr = 1; tick(); stats_clr = 0;
    cpu_req = 1; acc_req = 1; acc_lock = 1;
    repeat (5) tick();
    idle();
    #1;
    n_cmp++; if (cpu_stall_cnt !== 16'd5 || acc_stall_cnt !== 16'd0) begin n_err++;
      $display("FAIL stats_cnt got %0d/%0d want 5/0", cpu_stall_cnt, acc_stall_cnt); end
    stats_clr = 1; tick(); stats_clr = 0;
    n_cmp++; if (cpu_stall_cnt !== 16'd0) begin n_err++;
      $display("FAIL stats_clr got %0d want 0", cpu_stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_lock();
    test_back_to_back();
    test_reset_mid();
`ifdef ACCEL_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accel_mem_arbiter.md
# accel_mem_arbiter

Two-requester arbiter for port A of the accelerator's local dual-port RAM, sharing it between the CPU data bus and the Keccak accelerator FSM. It sits between the peripheral bus slave and the accelerator FSM on one side and the RAM port-A pins on the other. It grants one access per cycle, routes read data back to the issuing requester and bounds CPU starvation while the accelerator holds a lock.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and the RAM port
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_WAIT, 16, maximum consecutive stalled CPU cycles under lock; legal range ≥1
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req / cpu_we  in  1 each  CPU request, write enable
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH; cpu_be  in  DATA_WIDTH/8
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1; cpu_rdata  out  DATA_WIDTH  CPU response
- acc_req, acc_we, acc_addr, acc_wdata, acc_be, acc_gnt, acc_rvalid, acc_rdata: same as cpu_*, accelerator side
- acc_lock  in  1  accelerator is in a WRITE/READ transfer phase and gets priority
- mem_en, mem_we  out  1 each; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_be  out  DATA_WIDTH/8  RAM port A
- mem_rdata  in  DATA_WIDTH  RAM read data, available one cycle after mem_en
- owner  out  arb_owner_t  requester granted this cycle (OWN_NONE/OWN_CPU/OWN_ACC)

## Operation
- Grant is combinational, in the same cycle as req. At most one gnt per cycle.
- Single requester: it is granted.
- Both requesting, acc_lock=0: round-robin. The requester not granted last wins.
- Both requesting, acc_lock=1: the accelerator wins while cpu_wait < MAX_WAIT. When cpu_wait == MAX_WAIT, the CPU wins that one cycle.
- cpu_wait counter, $clog2(MAX_WAIT+1) bits:
  - increments when cpu_req && !cpu_gnt, saturating at MAX_WAIT;
  - clears on cpu_gnt or when !cpu_req.
- last_owner register updates only on a grant.
- Memory port: driven from the granted requester.
  - No grant: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Response tag register: {valid, owner} captured on every grant, reads and writes.
  - Next cycle, the tagged owner gets rvalid=1.
  - rdata=mem_rdata for a read; rdata=0 for a write.
  - The non-owner always sees rvalid=0, rdata=0.
- Protocol: a requester holds req and attributes stable until gnt. The arbiter does not check this.
- acc_lock deasserting with both pending: round-robin applies from that same cycle.

## Timing
- Reset values: gnts 0, rvalids 0, rdata 0, mem_* 0, owner OWN_NONE, cpu_wait 0, tag invalid, last_owner OWN_ACC (CPU wins the first tie).
- Latency: gnt at cycle N, rvalid at N+1. Back-to-back grants allowed every cycle.
- Reset mid-operation: all registers cleared immediately. A pending rvalid is dropped.
- Worst-case CPU stall under a continuous lock: MAX_WAIT cycles. Grant on cycle MAX_WAIT+1.
- MAX_WAIT=1 under lock: strict alternation starting with the accelerator.

## Configuration
- ACCEL_ARB_STATS_EN defined adds:
  - input stats_clr (1 bit);
  - outputs cpu_stall_cnt and acc_stall_cnt (16 bits each), counting cycles with req && !gnt per requester.
- Counter behaviour: saturates at 0xFFFF; stats_clr clears synchronously, and clear wins over increment; reset 0.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical.

## Structure
- cfg_types_pkg gets arb_owner_t (OWN_NONE, OWN_CPU, OWN_ACC) and ARB_STATS_WIDTH=16.
- One sub-module, accel_arb_stats: the two saturating counters. Instantiated only under ACCEL_ARB_STATS_EN.

## Test plan
- Only cpu_req, read addr 0x04, RAM holds 0xDEADBEEF -> cpu_gnt same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; acc_rvalid=0.
- Both requesting continuously, acc_lock=0 -> grants CPU, ACC, CPU, ACC...; first grant CPU after reset.
- Both requesting, acc_lock=1, MAX_WAIT=16 -> ACC granted 16 cycles, CPU granted cycle 17, then ACC again with cpu_wait restarting from 0.
- ACC write addr 0x10 data 0x12345678 followed by CPU read 0x10 -> acc_rvalid with rdata 0; CPU reads 0x12345678.
- rst_n asserted the cycle after a CPU grant -> no cpu_rvalid, all outputs 0; after release, the first tie goes to CPU.
- With ACCEL_ARB_STATS_EN: 5 CPU stall cycles -> cpu_stall_cnt=5; stats_clr pulse -> 0; forced 0xFFFF stays 0xFFFF on a further stall.
